// File: rtl/wb_sram_arb_pkg.sv
// Shared types and constants for the two-port Wishbone to async SRAM arbiter.
package wb_sram_arb_pkg;

  localparam int unsigned WB_ADR_W   = 19;
  localparam int unsigned SRAM_ADR_W = 18;
  localparam int unsigned SRAM_DQ_W  = 16;
  localparam int unsigned WB_DAT_W   = 32;
  localparam int unsigned WB_SEL_W   = 4;
  localparam int unsigned WORD_ADR_W = WB_ADR_W - 2;
  localparam int unsigned STATE_W    = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_SETUP = 3'd1;
  localparam logic [STATE_W-1:0] ST_STB   = 3'd2;
  localparam logic [STATE_W-1:0] ST_HOLD  = 3'd3;
  localparam logic [STATE_W-1:0] ST_ACK   = 3'd4;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // Request payload latched at grant time
  typedef struct packed {
    logic [WORD_ADR_W-1:0] adr;
    logic                  we;
    logic [WB_SEL_W-1:0]   sel;
    logic [WB_DAT_W-1:0]   dat;
  } wb_req_t;

  // Byte-lane pair belonging to one halfword
  function automatic logic [1:0] half_sel(input logic [WB_SEL_W-1:0] sel, input logic half);
    return half ? sel[3:2] : sel[1:0];
  endfunction

endpackage

// File: rtl/wb_sram_arb_rr.sv
// Two-way request/grant arbiter; WB_SRAM_ARB_FIXED_PRIO_EN selects fixed port-0 priority.
module wb_sram_arb_rr
  import wb_sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_idx_c
);

`ifdef WB_SRAM_ARB_FIXED_PRIO_EN
  logic unused_arb;
  assign unused_arb = &{1'b0, clk, rst_n, take, req[1]};
  assign gnt_idx_c  = ~req[0];
`else
  logic last_grant_q;

  // On a tie the port not served last time wins
  always_comb begin
    gnt_idx_c = req[1];
    if (req == 2'b11) gnt_idx_c = ~last_grant_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else if (take) last_grant_q <= gnt_idx_c;
  end
`endif

endmodule

// File: rtl/wb_sram_arbiter.sv
// Two-port Wishbone arbiter sequencing 32-bit accesses into timed 16-bit async SRAM cycles.
// Build option: WB_SRAM_ARB_FIXED_PRIO_EN (fixed port-0 priority instead of round-robin).
module wb_sram_arbiter
  import wb_sram_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [WB_SEL_W-1:0]   m0_sel_i,
  input  logic [WB_ADR_W-1:0]   m0_adr_i,
  input  logic [WB_DAT_W-1:0]   m0_dat_i,
  output logic [WB_DAT_W-1:0]   m0_dat_o,
  output logic                  m0_ack_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [WB_SEL_W-1:0]   m1_sel_i,
  input  logic [WB_ADR_W-1:0]   m1_adr_i,
  input  logic [WB_DAT_W-1:0]   m1_dat_i,
  output logic [WB_DAT_W-1:0]   m1_dat_o,
  output logic                  m1_ack_o,
  output logic [SRAM_ADR_W-1:0] sram_addr_o,
  output logic [SRAM_DQ_W-1:0]  sram_dq_o,
  input  logic [SRAM_DQ_W-1:0]  sram_dq_i,
  output logic                  sram_dq_oe_o,
  output logic                  sram_ce_n_o,
  output logic                  sram_oe_n_o,
  output logic                  sram_we_n_o,
  output logic                  sram_ub_n_o,
  output logic                  sram_lb_n_o
);

  localparam int unsigned CNT_W = 4;

  logic [STATE_W-1:0]    state_q, state_nxt;
  logic                  half_q, half_nxt;
  logic [CNT_W-1:0]      wait_q, wait_nxt;
  logic                  gnt_q, gnt_nxt;
  wb_req_t               req_q, req_nxt, m0_req_c, m1_req_c;
  logic [WB_DAT_W-1:0]   rdata_q, rdata_nxt;
  logic [1:0]            arb_req_c, lanes_c;
  logic                  arb_take_c, arb_idx_c, gnt_cyc_c;

  logic                  ack0_nxt, ack1_nxt, dq_oe_nxt;
  logic                  ce_n_nxt, oe_n_nxt, we_n_nxt, ub_n_nxt, lb_n_nxt;
  logic [WB_DAT_W-1:0]   dat0_nxt, dat1_nxt;
  logic [SRAM_ADR_W-1:0] addr_nxt;
  logic [SRAM_DQ_W-1:0]  dq_nxt;

  logic unused_adr;
  assign unused_adr = ^{m0_adr_i[1:0], m1_adr_i[1:0]};

  assign m0_req_c = '{adr: m0_adr_i[WB_ADR_W-1:2], we: m0_we_i, sel: m0_sel_i, dat: m0_dat_i};
  assign m1_req_c = '{adr: m1_adr_i[WB_ADR_W-1:2], we: m1_we_i, sel: m1_sel_i, dat: m1_dat_i};

  // A port being acked this cycle still shows its old request; ignore it
  assign arb_req_c = {m1_cyc_i & m1_stb_i & ~m1_ack_o, m0_cyc_i & m0_stb_i & ~m0_ack_o};
  assign gnt_cyc_c = gnt_q ? m1_cyc_i : m0_cyc_i;
  assign lanes_c   = half_sel(req_q.sel, half_q);

  wb_sram_arb_rr u_arb (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .req       (arb_req_c),
    .take      (arb_take_c),
    .gnt_idx_c (arb_idx_c)
  );

  // Next state plus pin values; pins follow the state one cycle later
  always_comb begin
    state_nxt  = state_q;
    half_nxt   = half_q;
    wait_nxt   = wait_q;
    gnt_nxt    = gnt_q;
    req_nxt    = req_q;
    rdata_nxt  = rdata_q;
    arb_take_c = 1'b0;
    ack0_nxt   = 1'b0;
    ack1_nxt   = 1'b0;
    dat0_nxt   = '0;
    dat1_nxt   = '0;
    addr_nxt   = sram_addr_o;
    dq_nxt     = sram_dq_o;
    dq_oe_nxt  = 1'b0;
    ce_n_nxt   = 1'b1;
    oe_n_nxt   = 1'b1;
    we_n_nxt   = 1'b1;
    ub_n_nxt   = 1'b1;
    lb_n_nxt   = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (|arb_req_c) begin
          arb_take_c = 1'b1;
          gnt_nxt    = arb_idx_c;
          req_nxt    = arb_idx_c ? m1_req_c : m0_req_c;
          rdata_nxt  = '0;
          if (|req_nxt.sel[1:0]) begin
            state_nxt = ST_SETUP;
            half_nxt  = HALF_LO;
          end else if (|req_nxt.sel[3:2]) begin
            state_nxt = ST_SETUP;
            half_nxt  = HALF_HI;
          end else begin
            state_nxt = ST_ACK;
          end
        end
      end
      ST_SETUP, ST_STB, ST_HOLD: begin
        ce_n_nxt  = 1'b0;
        addr_nxt  = {req_q.adr, half_q};
        ub_n_nxt  = ~lanes_c[1];
        lb_n_nxt  = ~lanes_c[0];
        dq_oe_nxt = req_q.we;
        dq_nxt    = half_q ? req_q.dat[31:16] : req_q.dat[15:0];
        if (state_q == ST_SETUP) begin
          state_nxt = ST_STB;
          wait_nxt  = CNT_W'(WAIT_CYCLES - 1);
        end else if (state_q == ST_STB) begin
          oe_n_nxt = req_q.we;
          we_n_nxt = ~req_q.we;
          if (wait_q == '0) state_nxt = ST_HOLD;
          else wait_nxt = wait_q - CNT_W'(1);
        end else begin
          // Pins still show the final strobe cycle here, so read data is stable
          if (!req_q.we) begin
            if (half_q) rdata_nxt[31:16] = sram_dq_i;
            else rdata_nxt[15:0] = sram_dq_i;
          end
          if (!gnt_cyc_c) begin
            state_nxt = ST_IDLE;
          end else if (half_q == HALF_LO && |req_q.sel[3:2]) begin
            state_nxt = ST_SETUP;
            half_nxt  = HALF_HI;
          end else begin
            state_nxt = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        ack0_nxt  = ~gnt_q;
        ack1_nxt  = gnt_q;
        dat0_nxt  = gnt_q ? '0 : rdata_q;
        dat1_nxt  = gnt_q ? rdata_q : '0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      half_q  <= HALF_LO;
      wait_q  <= '0;
      gnt_q   <= 1'b0;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_nxt;
      half_q  <= half_nxt;
      wait_q  <= wait_nxt;
      gnt_q   <= gnt_nxt;
      req_q   <= req_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      m0_ack_o     <= 1'b0;
      m1_ack_o     <= 1'b0;
      m0_dat_o     <= '0;
      m1_dat_o     <= '0;
      sram_addr_o  <= '0;
      sram_dq_o    <= '0;
      sram_dq_oe_o <= 1'b0;
      sram_ce_n_o  <= 1'b1;
      sram_oe_n_o  <= 1'b1;
      sram_we_n_o  <= 1'b1;
      sram_ub_n_o  <= 1'b1;
      sram_lb_n_o  <= 1'b1;
    end else begin
      m0_ack_o     <= ack0_nxt;
      m1_ack_o     <= ack1_nxt;
      m0_dat_o     <= dat0_nxt;
      m1_dat_o     <= dat1_nxt;
      sram_addr_o  <= addr_nxt;
      sram_dq_o    <= dq_nxt;
      sram_dq_oe_o <= dq_oe_nxt;
      sram_ce_n_o  <= ce_n_nxt;
      sram_oe_n_o  <= oe_n_nxt;
      sram_we_n_o  <= we_n_nxt;
      sram_ub_n_o  <= ub_n_nxt;
      sram_lb_n_o  <= lb_n_nxt;
    end
  end

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Directed self-checking bench for wb_sram_arbiter with a behavioural async SRAM.
module tb_wb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [18:0] m0_adr, m1_adr;
  logic [31:0] m0_dat, m1_dat, m0_dat_o, m1_dat_o;
  logic        m0_ack, m1_ack;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_sram_arbiter #(.WAIT_CYCLES(2)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack),
    .sram_addr_o(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe_o(dq_oe), .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n),
    .sram_ub_n_o(ub_n), .sram_lb_n_o(lb_n)
  );

  // Behavioural SRAM: writes land at each clock while ce_n/we_n are low, preset port for setup
  logic [15:0] mem [0:511];
  logic        pre_en = 1'b0;
  logic [8:0]  pre_a;
  logic [15:0] pre_d;

  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (ce_n === 1'b0 && we_n === 1'b0) begin
      if (lb_n === 1'b0) mem[sram_addr[8:0]][7:0]  <= sram_dq_o[7:0];
      if (ub_n === 1'b0) mem[sram_addr[8:0]][15:8] <= sram_dq_o[15:8];
    end
  end

  assign sram_dq_i = (ce_n === 1'b0 && oe_n === 1'b0) ? mem[sram_addr[8:0]] : 16'h0000;

  // Pin activity monitor, sampled mid-cycle
  int          we_cnt = 0, oe_cnt = 0, ce_cnt = 0, drv_cnt = 0, we_pulses = 0;
  logic        prev_we_n = 1'b1;
  logic [17:0] we_addr = '0;
  logic        we_ub = 1'b1, we_lb = 1'b1;

  always @(negedge clk) begin
    if (we_n === 1'b0) begin
      we_cnt++;
      we_addr = sram_addr;
      we_ub   = ub_n;
      we_lb   = lb_n;
      if (prev_we_n === 1'b1) we_pulses++;
    end
    if (oe_n === 1'b0) oe_cnt++;
    if (ce_n === 1'b0) ce_cnt++;
    if (dq_oe === 1'b1) drv_cnt++;
    prev_we_n = we_n;
  end

  int b_we, b_oe, b_ce, b_drv, b_pul;

  task automatic snap();
    b_we = we_cnt; b_oe = oe_cnt; b_ce = ce_cnt; b_drv = drv_cnt; b_pul = we_pulses;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preset(input logic [8:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_a = a; pre_d = d; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic drive(input int p, input logic on, input logic we, input logic [3:0] sel,
                       input logic [18:0] adr, input logic [31:0] dat);
    if (p == 0) begin
      m0_cyc = on; m0_stb = on; m0_we = we; m0_sel = sel; m0_adr = adr; m0_dat = dat;
    end else begin
      m1_cyc = on; m1_stb = on; m1_we = we; m1_sel = sel; m1_adr = adr; m1_dat = dat;
    end
  endtask

  // Single transfer; lat = index of the edge after which ack is seen (request edge = 0)
  task automatic wb_xfer(input int p, input logic we, input logic [3:0] sel, input logic [18:0] adr,
                         input logic [31:0] dat, output logic [31:0] rdat, output int lat);
    logic ack;
    repeat (2) @(negedge clk);
    snap();
    drive(p, 1'b1, we, sel, adr, dat);
    lat  = -1;
    rdat = '0;
    for (int e = 0; e < 40 && lat < 0; e++) begin
      @(posedge clk); #1;
      ack = (p == 0) ? m0_ack : m1_ack;
      if (ack) begin
        lat  = e;
        rdat = (p == 0) ? m0_dat_o : m1_dat_o;
      end
    end
    drive(p, 1'b0, 1'b0, 4'h0, '0, '0);
  endtask

  // Both ports read the same word in the same cycle; report who was acked first
  task automatic tie_pair(output int first, output logic [31:0] d0, output logic [31:0] d1);
    logic done0, done1;
    repeat (2) @(negedge clk);
    drive(0, 1'b1, 1'b0, 4'hF, 19'h00100, '0);
    drive(1, 1'b1, 1'b0, 4'hF, 19'h00100, '0);
    first = -1; done0 = 1'b0; done1 = 1'b0; d0 = '0; d1 = '0;
    for (int e = 0; e < 60 && !(done0 && done1); e++) begin
      @(posedge clk); #1;
      if (m0_ack && !done0) begin
        done0 = 1'b1; d0 = m0_dat_o;
        if (first < 0) first = 0;
        drive(0, 1'b0, 1'b0, 4'h0, '0, '0);
      end
      if (m1_ack && !done1) begin
        done1 = 1'b1; d1 = m1_dat_o;
        if (first < 0) first = 1;
        drive(1, 1'b0, 1'b0, 4'h0, '0, '0);
      end
    end
    check("tie_both_served", 32'({done0, done1}), 32'h3);
  endtask

  logic [31:0] rd, d0, d1;
  int          lat, first, exp_first3;
  logic        ack_seen;

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 4'h0, '0, '0);
    drive(1, 1'b0, 1'b0, 4'h0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'({m0_ack, m1_ack}), 32'h0);
    check("rst_dat", m0_dat_o | m1_dat_o, 32'h0);
    check("rst_addr", 32'(sram_addr), 32'h0);
    check("rst_dq", 32'({sram_dq_o, 15'h0, dq_oe}), 32'h0);
    check("rst_strobes", 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1F);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) preset(9'(12'h080 + i), 16'h0000);

    // Ties straight after reset, then again after m1 was last served
    tie_pair(first, d0, d1);
    check("tie1_first", 32'(first), 32'd0);
    tie_pair(first, d0, d1);
    check("tie2_first", 32'(first), 32'd0);

    wb_xfer(0, 1'b1, 4'hF, 19'h00100, 32'hDEADBEEF, rd, lat);
    check("wr_lat", 32'(lat), 32'd9);
    check("wr_mem_lo", 32'(mem[9'h080]), 32'h0000BEEF);
    check("wr_mem_hi", 32'(mem[9'h081]), 32'h0000DEAD);
    check("wr_we_cycles", 32'(we_cnt - b_we), 32'd4);
    check("wr_we_pulses", 32'(we_pulses - b_pul), 32'd2);
    check("wr_dq_oe", 32'(drv_cnt - b_drv), 32'd8);

    // m0 was served last: round-robin favours m1 on this tie
`ifdef WB_SRAM_ARB_FIXED_PRIO_EN
    exp_first3 = 0;
`else
    exp_first3 = 1;
`endif
    tie_pair(first, d0, d1);
    check("tie3_first", 32'(first), 32'(exp_first3));
    check("tie3_m0_dat", d0, 32'hDEADBEEF);
    check("tie3_m1_dat", d1, 32'hDEADBEEF);

    wb_xfer(1, 1'b0, 4'hF, 19'h00100, '0, rd, lat);
    check("rd_lat", 32'(lat), 32'd9);
    check("rd_dat", rd, 32'hDEADBEEF);
    check("rd_oe_cycles", 32'(oe_cnt - b_oe), 32'd4);
    check("rd_dq_oe", 32'(drv_cnt - b_drv), 32'd0);
    check("rd_we_cycles", 32'(we_cnt - b_we), 32'd0);

    preset(9'h100, 16'h1111);
    preset(9'h101, 16'h2233);
    wb_xfer(0, 1'b1, 4'b0100, 19'h00200, 32'h00AA0000, rd, lat);
    check("lane_lat", 32'(lat), 32'd5);
    check("lane_addr", 32'(we_addr), 32'h101);
    check("lane_ub_lb", 32'({we_ub, we_lb}), 32'h2);
    check("lane_mem_hi", 32'(mem[9'h101]), 32'h22AA);
    check("lane_mem_lo", 32'(mem[9'h100]), 32'h1111);
    check("lane_we_cycles", 32'(we_cnt - b_we), 32'd2);

    wb_xfer(1, 1'b0, 4'h0, 19'h00100, '0, rd, lat);
    check("empty_lat", 32'(lat), 32'd1);
    check("empty_ce", 32'(ce_cnt - b_ce), 32'd0);
    check("empty_dat", rd, 32'h0);

    // Drop cyc while halfword 0 is strobing
    preset(9'h180, 16'h5555);
    preset(9'h181, 16'h6666);
    repeat (2) @(negedge clk);
    snap();
    drive(0, 1'b1, 1'b1, 4'hF, 19'h00300, 32'h12345678);
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 4'h0, '0, '0);
    ack_seen = 1'b0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (m0_ack || m1_ack) ack_seen = 1'b1;
    end
    check("abort_no_ack", 32'(ack_seen), 32'h0);
    check("abort_mem_lo", 32'(mem[9'h180]), 32'h5678);
    check("abort_mem_hi", 32'(mem[9'h181]), 32'h6666);
    check("abort_we_cycles", 32'(we_cnt - b_we), 32'd2);

    // Reset in the middle of a read strobe
    repeat (2) @(negedge clk);
    drive(0, 1'b1, 1'b0, 4'hF, 19'h00100, '0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_oe_low", 32'(oe_n), 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1F);
    check("mid_rst_addr", 32'(sram_addr), 32'h0);
    check("mid_rst_misc", 32'({m0_ack, m1_ack, dq_oe}), 32'h0);
    drive(0, 1'b0, 1'b0, 4'h0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    wb_xfer(0, 1'b0, 4'hF, 19'h00100, '0, rd, lat);
    check("post_rst_lat", 32'(lat), 32'd9);
    check("post_rst_dat", rd, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
